// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequential word fetch with one outstanding memory request.
// Redirects become buffer clear/align pulses; stale or back-pressured responses are dropped.
module fetch_ctrl #(
    parameter logic [31:0] reset_pc = 32'h0
) (
    input  logic        reset,
    input  logic        clock,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_error,
    input  logic        buf_stall,
    output logic        buf_ready,
    output logic [31:0] buf_pc,
    output logic [31:0] buf_rdata,
    output logic        buf_error,
    output logic        buf_clear,
    output logic        buf_align
);
    typedef enum logic [1:0] {INIT, REQ, FLUSH, STALL} state_t;
    state_t      state;
    logic [29:0] pc;
    logic [30:0] tgt;
    logic        unused;
    assign unused    = ^{redir_pc[0], tgt[0]};
    assign mem_valid = reset && (state == REQ || state == FLUSH);
    assign mem_addr  = mem_valid ? {pc, 2'b00} : '0;
    assign buf_clear = reset && (state == INIT || redir_valid);
    assign buf_align = reset && (redir_valid ? redir_pc[1] : state == INIT && reset_pc[1]);
    assign buf_ready = reset && state == REQ && mem_ready && !redir_valid && !buf_stall;
    assign buf_pc    = buf_ready ? {pc, 2'b00} : '0;
    assign buf_rdata = buf_ready ? mem_rdata : '0;
    assign buf_error = buf_ready && mem_error;
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= INIT;
            pc    <= reset_pc[31:2];
            tgt   <= '0;
        end else begin
            case (state)
                INIT: begin
                    state <= REQ;
                    if (redir_valid) pc <= redir_pc[31:2];
                end
                REQ: begin
                    if (redir_valid && mem_ready) pc <= redir_pc[31:2];
                    else if (redir_valid) begin
                        tgt   <= redir_pc[31:1];
                        state <= FLUSH;
                    end else if (mem_ready && buf_stall) state <= STALL;
                    else if (mem_ready) pc <= pc + 30'd1;
                end
                FLUSH: begin
                    if (redir_valid) tgt <= redir_pc[31:1];
                    if (mem_ready) begin
                        pc    <= redir_valid ? redir_pc[31:2] : tgt[30:1];
                        state <= REQ;
                    end
                end
                default: begin
                    if (redir_valid) pc <= redir_pc[31:2];
                    if (redir_valid || !buf_stall) state <= REQ;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed stimulus, per-cycle address-level reference model and hand-computed checks.
module tb_fetch_ctrl;
    localparam logic [31:0] RPC = 32'h8000_0002;
    localparam logic [31:0] KEY = 32'hA5C3_0000;
    logic        reset = 1'b0, clock = 1'b0;
    logic        redir_valid = 1'b0, mem_ready = 1'b0, mem_error = 1'b0, buf_stall = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        mem_valid, buf_ready, buf_error, buf_clear, buf_align;
    logic [31:0] mem_addr, mem_rdata, buf_pc, buf_rdata;
    int          n_checks = 0, n_fail = 0;

    fetch_ctrl #(.reset_pc(RPC)) dut (
        .reset(reset), .clock(clock), .redir_valid(redir_valid), .redir_pc(redir_pc),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_error(mem_error), .buf_stall(buf_stall),
        .buf_ready(buf_ready), .buf_pc(buf_pc), .buf_rdata(buf_rdata),
        .buf_error(buf_error), .buf_clear(buf_clear), .buf_align(buf_align)
    );

    always #5 clock = ~clock;
    assign mem_rdata = mem_addr ^ KEY;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which address is being fetched, whether its answer is stale,
    // where to go after the stale answer, and whether fetching is paused by the buffer.
    bit          m_init = 1'b0, m_fetching = 1'b0, m_stale = 1'b0;
    logic [31:0] m_addr = '0, m_next = '0, last_pc = '0;
    bit          have_last = 1'b0;

    always @(negedge clock) begin
        logic        e_clear, e_align, e_acc;
        logic [31:0] r_word;
        r_word  = redir_pc & ~32'h3;
        e_clear = reset && (m_init || redir_valid);
        e_align = reset && (redir_valid ? redir_pc[1] : m_init && RPC[1]);
        e_acc   = reset && m_fetching && !m_stale && mem_ready && !redir_valid && !buf_stall;
        chk("mem_valid", {31'b0, mem_valid}, {31'b0, reset && m_fetching});
        chk("mem_addr", mem_addr, (reset && m_fetching) ? m_addr : 32'h0);
        chk("buf_clear", {31'b0, buf_clear}, {31'b0, e_clear});
        chk("buf_align", {31'b0, buf_align}, {31'b0, e_align});
        chk("buf_ready", {31'b0, buf_ready}, {31'b0, e_acc});
        chk("buf_pc", buf_pc, e_acc ? m_addr : 32'h0);
        chk("buf_rdata", buf_rdata, e_acc ? (m_addr ^ KEY) : 32'h0);
        chk("buf_error", {31'b0, buf_error}, {31'b0, e_acc && mem_error});
        if (e_clear || !reset) have_last = 1'b0;
        if (e_acc) begin
            if (have_last) chk("seq_pc", buf_pc, last_pc + 32'd4);
            last_pc   = buf_pc;
            have_last = 1'b1;
        end
        if (!reset) begin
            m_init = 1'b1; m_fetching = 1'b0; m_stale = 1'b0; m_addr = RPC & ~32'h3;
        end else if (m_init) begin
            m_init = 1'b0; m_fetching = 1'b1;
            if (redir_valid) m_addr = r_word;
        end else if (!m_fetching) begin
            if (redir_valid) m_addr = r_word;
            if (redir_valid || !buf_stall) m_fetching = 1'b1;
        end else if (m_stale) begin
            if (redir_valid) m_next = r_word;
            if (mem_ready) begin m_addr = m_next; m_stale = 1'b0; end
        end else if (redir_valid) begin
            if (mem_ready) m_addr = r_word;
            else begin m_stale = 1'b1; m_next = r_word; end
        end else if (mem_ready) begin
            if (buf_stall) m_fetching = 1'b0;
            else m_addr = m_addr + 32'd4;
        end
    end

    task automatic step(input logic rst, input logic rdy, input logic rv, input logic [31:0] rp,
                        input logic st, input logic er);
        @(posedge clock);
        #1;
        reset = rst; mem_ready = rdy; redir_valid = rv; redir_pc = rp; buf_stall = st; mem_error = er;
        @(negedge clock);
        #1;
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0);
        chk("rst_valid", {31'b0, mem_valid}, 32'h0);
        step(0, 1, 0, 0, 0, 0);
        chk("rst_clear", {31'b0, buf_clear}, 32'h0);
        step(1, 1, 0, 0, 0, 0);
        chk("init_clear", {30'b0, buf_clear, buf_align}, 32'h3);
        chk("init_ready", {31'b0, buf_ready}, 32'h0);
        step(1, 1, 0, 0, 0, 0);
        chk("seq0_addr", mem_addr, 32'h8000_0000);
        chk("seq0_pc", buf_pc, 32'h8000_0000);
        step(1, 1, 0, 0, 0, 0);
        chk("seq1_pc", buf_pc, 32'h8000_0004);
        step(1, 1, 0, 0, 0, 0);
        chk("seq2_addr", mem_addr, 32'h8000_0008);
        chk("seq2_rdata", buf_rdata, 32'h8000_0008 ^ KEY);
        // wait states with a redirect while the request is in flight
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 32'h0000_1006, 0, 0);
        chk("flush_clear", {30'b0, buf_clear, buf_align}, 32'h3);
        step(1, 0, 0, 0, 0, 0);
        chk("flush_addr", mem_addr, 32'h8000_000C);
        step(1, 1, 0, 0, 0, 0);
        chk("stale_drop", {31'b0, buf_ready}, 32'h0);
        step(1, 0, 0, 0, 0, 0);
        chk("redir_addr", mem_addr, 32'h0000_1004);
        // redirect coinciding with a response
        step(1, 1, 1, 32'h0000_0200, 0, 0);
        chk("redir_rdy_drop", {31'b0, buf_ready}, 32'h0);
        step(1, 1, 0, 0, 0, 0);
        chk("redir200_addr", mem_addr, 32'h0000_0200);
        chk("redir200_pc", buf_pc, 32'h0000_0200);
        // buffer back-pressure at 0x40
        step(1, 1, 1, 32'h0000_0040, 0, 0);
        step(1, 1, 0, 0, 1, 0);
        chk("stall_drop", {31'b0, buf_ready}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 1, 0);
            chk("stall_valid", {31'b0, mem_valid}, 32'h0);
        end
        step(1, 0, 0, 0, 0, 0);
        chk("stall_rel_valid", {31'b0, mem_valid}, 32'h0);
        step(1, 1, 0, 0, 0, 0);
        chk("refetch_addr", mem_addr, 32'h0000_0040);
        chk("refetch_pc", buf_pc, 32'h0000_0040);
        // access fault is forwarded, fetching continues
        step(1, 1, 1, 32'h0000_0010, 0, 0);
        step(1, 1, 0, 0, 0, 1);
        chk("err_pc", {buf_pc[31:1], buf_error}, 32'h0000_0011);
        step(1, 1, 0, 0, 0, 0);
        chk("after_err", {buf_pc[31:1], buf_error}, 32'h0000_0014);
        // address wrap, then reset mid-request
        step(1, 1, 1, 32'hFFFF_FFFC, 0, 0);
        chk("wrap_align", {31'b0, buf_align}, 32'h0);
        step(1, 1, 0, 0, 0, 0);
        chk("wrap_pc", buf_pc, 32'hFFFF_FFFC);
        step(1, 0, 0, 0, 0, 0);
        chk("wrap_addr", mem_addr, 32'h0000_0000);
        step(0, 1, 0, 0, 0, 0);
        chk("mid_rst_out", {mem_valid, buf_ready, buf_clear, buf_align, buf_error} , 32'h0);
        chk("mid_rst_addr", mem_addr | buf_pc | buf_rdata, 32'h0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        chk("rinit_clear", {30'b0, buf_clear, buf_ready}, 32'h2);
        step(1, 1, 0, 0, 0, 0);
        chk("rinit_pc", buf_pc, 32'h8000_0000);
        // double redirect while flushing
        step(1, 0, 1, 32'h0000_0300, 0, 0);
        step(1, 0, 1, 32'h0000_0502, 0, 0);
        chk("flush2_clear", {30'b0, buf_clear, buf_align}, 32'h3);
        step(1, 1, 0, 0, 0, 0);
        chk("flush2_drop", {31'b0, buf_ready}, 32'h0);
        step(1, 1, 0, 0, 0, 0);
        chk("flush2_pc", buf_pc, 32'h0000_0500);
        // redirect while stalled
        step(1, 1, 0, 0, 1, 0);
        step(1, 0, 1, 32'h0000_0700, 1, 0);
        chk("stall_redir_valid", {31'b0, mem_valid}, 32'h0);
        step(1, 1, 0, 0, 0, 0);
        chk("stall_redir_pc", buf_pc, 32'h0000_0700);
        step(1, 0, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
